vedic_mult_pipe: RTL and testbench

//  Parametrised, pipelined Urdhva-Tiryagbhyam (Vedic) multiplier, WIDTH x WIDTH -> 2*WIDTH.

---
 rtl/vedic_mult_pipe.sv | 138 +++++++++++++
 tb/tb_vedic_mult_pipe.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vedic_mult_pipe.sv
// Pipelined Urdhva-Tiryagbhyam multiplier: 2x2 Vedic leaves are recombined one level per register
// stage; signed operands are multiplied as magnitudes and the sign is applied in the last stage.
module vedic_mult_pipe #(
    parameter int WIDTH  = 8,
    parameter int LEVELS = $clog2(WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic                 in_signed,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_p
);

    logic             adv;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic             neg_in;

    // The whole pipe moves in lockstep: only a held output stalls it.
    assign adv      = ~(out_valid & ~out_ready);
    assign in_ready = adv;

    // |-2^(W-1)| wraps to 2^(W-1), which is still correct read as unsigned.
    assign mag_a  = (in_signed && in_a[WIDTH-1]) ? -in_a : in_a;
    assign mag_b  = (in_signed && in_b[WIDTH-1]) ? -in_b : in_b;
    assign neg_in = in_signed & (in_a[WIDTH-1] ^ in_b[WIDTH-1]);

    function automatic logic [3:0] vedic2x2(input logic [1:0] a, input logic [1:0] b);
        logic t1;
        logic t2;
        logic t3;
        logic c1;
        t1 = a[1] & b[0];
        t2 = a[0] & b[1];
        c1 = t1 & t2;
        t3 = a[1] & b[1];
        return {t3 & c1, t3 ^ c1, t1 ^ t2, a[0] & b[0]};
    endfunction

    // Level k holds (WIDTH/2^k)^2 partial products of 2^k x 2^k operand chunks;
    // block (i,j) is chunk i of a times chunk j of b, stored at index i*M+j.
    for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
        localparam int N  = 1 << k;
        localparam int M  = WIDTH / N;
        localparam int PW = 2 * N;

        logic              vld_d;
        logic              neg_d;
        logic [M*M*PW-1:0] prod_c;

        if (k == 1) begin : g_leaf
            assign vld_d = in_valid;
            assign neg_d = neg_in;

            // NOTE: every always_comb output gets a default first so no path can infer a latch.
            always_comb begin
                prod_c = '0;
                for (int i = 0; i < M; i++) begin
                    for (int j = 0; j < M; j++) begin
                        prod_c[(i*M+j)*PW +: PW] = vedic2x2(mag_a[2*i +: 2], mag_b[2*j +: 2]);
                    end
                end
            end
        end else begin : g_join
            localparam int MP = 2 * M;
            localparam int H  = N / 2;

            logic [MP*MP*N-1:0] prev;

            assign vld_d = g_lvl[k-1].g_reg.vld_q;
            assign neg_d = g_lvl[k-1].g_reg.neg_q;
            assign prev  = g_lvl[k-1].g_reg.prod_q;

            always_comb begin
                logic [PW-1:0] ll;
                logic [PW-1:0] hl;
                logic [PW-1:0] lh;
                logic [PW-1:0] hh;
                prod_c = '0;
                ll     = '0;
                hl     = '0;
                lh     = '0;
                hh     = '0;
                for (int i = 0; i < M; i++) begin
                    for (int j = 0; j < M; j++) begin
                        ll = PW'(prev[((2*i)  *MP + 2*j)  *N +: N]);
                        hl = PW'(prev[((2*i+1)*MP + 2*j)  *N +: N]);
                        lh = PW'(prev[((2*i)  *MP + 2*j+1)*N +: N]);
                        hh = PW'(prev[((2*i+1)*MP + 2*j+1)*N +: N]);
                        prod_c[(i*M+j)*PW +: PW] = (hh << N) + ((hl + lh) << H) + ll;
                    end
                end
            end
        end

        if (k < LEVELS) begin : g_reg
            logic              vld_q;
            logic              neg_q;
            logic [M*M*PW-1:0] prod_q;

            // NOTE: sequential state is written with non-blocking assignments only.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld_q <= 1'b0;
                end else if (adv) begin
                    vld_q <= vld_d;
                end
            end

            // NOTE: data registers carry no reset; the valid bits alone decide what is meaningful.
            always_ff @(posedge clk) begin
                if (adv && vld_d) begin
                    prod_q <= prod_c;
                    neg_q  <= neg_d;
                end
            end
        end else begin : g_out
            // Single block remains (M == 1), so prod_c is the full 2*WIDTH magnitude.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    out_valid <= 1'b0;
                    out_p     <= '0;
                end else if (adv) begin
                    out_valid <= vld_d;
                    if (vld_d) begin
                        out_p <= neg_d ? -prod_c : prod_c;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_vedic_mult_pipe.sv
// Self-checking bench: WIDTH=8 directed/streaming/backpressure/reset tests against a plain
// arithmetic model, plus WIDTH=2,4,16 sweeps with latency checks.
module tb_vedic_mult_pipe;

    logic        clk;
    logic        rst_n;
    logic        sweep_rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_a;
    logic [7:0]  in_b;
    logic        in_signed;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_p;

    int          n_cmp = 0;
    int          n_fail = 0;
    int          out_count = 0;
    int          sweep_fin = 0;
    logic [15:0] exp_q[$];

    vedic_mult_pipe #(.WIDTH(8)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_signed (in_signed),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_p     (out_p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic logic [15:0] model8(input logic [7:0] a, input logic [7:0] b, input logic s);
        longint av;
        longint bv;
        av = s ? longint'($signed(a)) : longint'(a);
        bv = s ? longint'($signed(b)) : longint'(b);
        return 16'(av * bv);
    endfunction

    // Scoreboard: record every accepted input, check every presented output in order.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out_valid", out_valid, 1'b0);
                end else begin
                    check("out_p", out_p, exp_q[0]);
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        out_count++;
                    end
                end
            end
            if (in_valid && in_ready) exp_q.push_back(model8(in_a, in_b, in_signed));
        end
    end

    task automatic directed(input string name, input logic [7:0] a, input logic [7:0] b,
                            input logic s, input logic [15:0] exp);
        int lat;
        @(posedge clk); #1;
        in_a = a; in_b = b; in_signed = s; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; in_a = 'x; in_b = 'x; in_signed = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        check({name, "_latency"}, lat, 3);
        check(name, out_p, exp);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
        #1;
        check(name, exp_q.size(), 0);
    endtask

    logic [7:0] bp_a[12];
    logic [7:0] bp_b[12];
    logic       bp_s[12];

    initial begin
        int          base;
        int          idx;
        int          cyc;
        logic        xfer;
        logic [15:0] held;

        in_valid = 1'b0; in_a = '0; in_b = '0; in_signed = 1'b0; out_ready = 1'b1;
        rst_n = 1'b0; sweep_rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_p", out_p, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1; sweep_rst_n = 1'b1;

        directed("u_ff_ff",    8'hFF, 8'hFF, 1'b0, 16'hFE01);
        directed("s_m1_m1",    8'hFF, 8'hFF, 1'b1, 16'h0001);
        directed("s_m128_127", 8'h80, 8'h7F, 1'b1, 16'hC080);
        directed("s_m128_m128",8'h80, 8'h80, 1'b1, 16'h4000);
        directed("s_0_neg",    8'h00, 8'h85, 1'b1, 16'h0000);
        directed("u_80_7f",    8'h80, 8'h7F, 1'b0, 16'h3F80);
        directed("s_127_m127", 8'h7F, 8'h81, 1'b1, 16'hC0FF);
        drain("directed_drain");

        // 16 back-to-back mixed-mode operations at full rate.
        base = out_count;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1;
            in_a = 8'($urandom); in_b = 8'($urandom); in_signed = 1'($urandom); in_valid = 1'b1;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("stream_one_per_cycle", out_count - base, 16);
        drain("stream_drain");

        // Backpressure: out_ready low for cycles 5..9 while the source keeps offering.
        for (int i = 0; i < 12; i++) begin
            bp_a[i] = 8'($urandom); bp_b[i] = 8'($urandom); bp_s[i] = 1'($urandom);
        end
        base = out_count; idx = 0; cyc = 0; held = '0;
        while (idx < 12 && cyc < 100) begin
            in_a = bp_a[idx]; in_b = bp_b[idx]; in_signed = bp_s[idx]; in_valid = 1'b1;
            out_ready = !(cyc >= 5 && cyc < 10);
            @(negedge clk);
            xfer = in_ready;
            if (cyc == 2) check("bp_in_ready_high", in_ready, 1'b1);
            if (cyc == 6) held = out_p;
            if (cyc == 7) check("bp_in_ready_low", in_ready, 1'b0);
            if (cyc == 9) begin
                check("bp_held_valid", out_valid, 1'b1);
                check("bp_held_p", out_p, held);
            end
            @(posedge clk); #1;
            if (xfer) idx++;
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        drain("bp_drain");
        check("bp_no_loss_no_dup", out_count - base, 12);

        // Reset with three operations in flight.
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            in_a = 8'($urandom); in_b = 8'($urandom); in_signed = 1'($urandom); in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_in_ready", in_ready, 1'b1);
        check("midrst_out_p", out_p, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) begin
            @(posedge clk); #1;
            check("midrst_no_ghost", out_valid, 1'b0);
        end

        for (int i = 0; i < 8000 && sweep_fin < 3; i++) @(posedge clk);
        check("sweep_all_done", sweep_fin, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Other widths: exhaustive for 2 and 4 (both modes), random for 16; each result must
    // appear exactly $clog2(W) cycles after its input transfer.
    for (genvar g = 0; g < 3; g++) begin : g_sweep
        localparam int W    = (g == 0) ? 2 : (g == 1) ? 4 : 16;
        localparam int L    = $clog2(W);
        localparam int NOPS = (W == 2) ? 32 : (W == 4) ? 512 : 256;

        logic [W-1:0]   sa;
        logic [W-1:0]   sb;
        logic           ss;
        logic           sv;
        logic           sir;
        logic           sov;
        logic [2*W-1:0] sp;

        vedic_mult_pipe #(.WIDTH(W)) u_sweep (
            .clk       (clk),
            .rst_n     (sweep_rst_n),
            .in_valid  (sv),
            .in_ready  (sir),
            .in_a      (sa),
            .in_b      (sb),
            .in_signed (ss),
            .out_valid (sov),
            .out_ready (1'b1),
            .out_p     (sp)
        );

        initial begin : p_sweep
            logic [2*W-1:0] eq[$];
            int             sq[$];
            int             cyc;
            int             sent;
            int             op;
            logic [W-1:0]   a;
            logic [W-1:0]   b;
            logic           s;
            longint         av;
            longint         bv;
            logic [2*W-1:0] e;

            cyc = 0; sent = 0; e = '0;
            sa = '0; sb = '0; ss = 1'b0; sv = 1'b0;
            wait (sweep_rst_n === 1'b1);
            while ((sent < NOPS || eq.size() > 0) && cyc < NOPS + 64) begin
                @(posedge clk); #1;
                cyc++;
                if (sent < NOPS) begin
                    if (W <= 4) begin
                        op = sent;
                        a  = W'(op);
                        b  = W'(op >> W);
                        s  = 1'((op >> (2 * W)) & 1);
                    end else begin
                        a = W'($urandom);
                        b = W'($urandom);
                        s = 1'($urandom);
                    end
                    av = s ? longint'($signed(a)) : longint'(a);
                    bv = s ? longint'($signed(b)) : longint'(b);
                    e  = (2 * W)'(av * bv);
                    sa = a; sb = b; ss = s; sv = 1'b1;
                end else begin
                    sv = 1'b0;
                end
                @(negedge clk);
                if (sov) begin
                    if (eq.size() == 0) begin
                        check($sformatf("w%0d_unexpected", W), sov, 1'b0);
                    end else begin
                        check($sformatf("w%0d_p", W), sp, eq.pop_front());
                        check($sformatf("w%0d_latency", W), cyc - sq.pop_front(), L);
                    end
                end
                if (sv && sir) begin
                    eq.push_back(e);
                    sq.push_back(cyc);
                    sent++;
                end
            end
            check($sformatf("w%0d_sent", W), sent, NOPS);
            check($sformatf("w%0d_drained", W), eq.size(), 0);
            sweep_fin++;
        end
    end

endmodule
